// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hack_pkg
//  Description : Shared word width, arbiter state encoding and the wdata
//                slice helper for the register write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Low bit of requester idx's word inside a packed NUM_REQ*WORD_W bus.
  function automatic int slice_lo(input int idx);
    return idx * WORD_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_write_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Returns the first set
//                request at or above ptr, wrapping N-1 -> 0, as a one-hot
//                winner plus a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  // Walk the request vector starting at ptr; the first hit wins.
  always_comb begin
    int                jj;
    logic [PTR_W-1:0]  j;
    winner = '0;
    valid  = 1'b0;
    jj     = 0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      jj = int'(ptr) + k;
      if (jj >= N) begin
        jj = jj - N;
      end
      j = PTR_W'(jj);
      if (!valid && req[j]) begin
        winner[j] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : register_write_arbiter
//  Description : Round-robin arbiter sharing one 16-bit register between
//                NUM_REQ writers, with a bounded per-grantee burst lock.
//                Drives the register's in/load pins directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_write_arbiter
  import hack_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*WORD_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [WORD_W-1:0]         reg_in,
  output logic                      reg_load,
  output logic                      busy
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
  localparam logic [PTR_W-1:0]  c_ptr_last  = PTR_W'(NUM_REQ - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    w_rr_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;

  logic [PTR_W-1:0]    w_gnt_idx;
  logic [PTR_W-1:0]    w_ptr_inc;
  logic [PTR_W-1:0]    w_arb_ptr;
  logic                w_grantee_req;
  logic                w_grantee_lock;
  logic                w_release;
  logic [NUM_REQ-1:0]  w_win;
  logic                w_win_valid;

  // Grantee's request/lock; lock from anyone else is masked out by gnt.
  assign w_grantee_req  = |(r_gnt & req);
  assign w_grantee_lock = |(r_gnt & lock);

  // Encode the one-hot grant into an index for pointer advance.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_gnt_idx = PTR_W'(i);
      end
    end
  end

  // Release on withdrawal, unlocked single write, or hitting the hold bound.
  assign w_release = (r_state == GRANT) &&
                     (!w_grantee_req || !w_grantee_lock || (r_hold_cnt == c_hold_last));

  assign w_ptr_inc = (w_gnt_idx == c_ptr_last) ? '0 : (w_gnt_idx + PTR_W'(1));

  // Arbitration on release uses the already-advanced pointer, so the
  // releasing requester is searched last and the hand-over has no bubble.
  assign w_arb_ptr = w_release ? w_ptr_inc : r_rr_ptr;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req    (req),
    .ptr    (w_arb_ptr),
    .winner (w_win),
    .valid  (w_win_valid)
  );

  // State, grant, pointer and hold counter register; async reset aborts bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next-state: arbitrate from IDLE or on release, otherwise extend the burst.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      IDLE: begin
        w_hold_cnt_nxt = '0;
        if (w_win_valid) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_win;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_rr_ptr_nxt   = w_ptr_inc;
          w_hold_cnt_nxt = '0;
          if (w_win_valid) begin
            w_gnt_nxt = w_win;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_gnt_nxt      = '0;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  // Data mux: OR of the granted slice; zero when nothing is granted.
  always_comb begin
    reg_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        reg_in = reg_in | wdata[slice_lo(i) +: WORD_W];
      end
    end
  end

  assign gnt      = r_gnt;
  assign reg_load = w_grantee_req;
  assign busy     = (r_state == GRANT);

endmodule
`default_nettype wire
